// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : synth_pkg
//  Description : Shared constants and types for the voice allocator slice:
//                voice count and word widths, the one-hot voice type, the
//                allocator state/action encodings and the captured event.
//  Revision    : 1.0  initial release
// ============================================================================
package synth_pkg;

    localparam int NUM_VOICES = 8;
    localparam int DW         = 16;
    localparam int NOTE_W     = 7;
    localparam int PTR_W      = $clog2(NUM_VOICES);

    typedef logic [NUM_VOICES-1:0] voice_onehot_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MATCH = 2'd1,
        APPLY = 2'd2
    } alloc_state_t;

    typedef enum logic [2:0] {
        RETRIG  = 3'd0,
        ALLOC   = 3'd1,
        STEAL   = 3'd2,
        RELEASE = 3'd3,
        DROP    = 3'd4
    } alloc_action_t;

    typedef struct packed {
        logic              on;
        logic [NOTE_W-1:0] note;
        logic [DW-1:0]     data;
    } note_evt_t;

endpackage
`default_nettype wire

// File: rtl/voice_allocator_if.sv
`default_nettype none
// ============================================================================
//  Interface   : voice_allocator_if
//  Description : Event handshake from the key decoder plus the per-voice
//                register view and status pulses fed to the voice bank.
//                master = event source / consumer, slave = allocator.
//  Revision    : 1.0  initial release
// ============================================================================
interface voice_allocator_if;
    import synth_pkg::*;

    logic              evt_valid;
    logic              evt_ready;
    logic              evt_on;
    logic [NOTE_W-1:0] evt_note;
    logic [DW-1:0]     evt_data;

    voice_onehot_t     voice_gate;
    logic [NOTE_W-1:0] voice_note [NUM_VOICES];
    logic [DW-1:0]     voice_data [NUM_VOICES];
    voice_onehot_t     voice_trig;
    logic              steal;
    logic              drop;

    modport master (
        output evt_valid, evt_on, evt_note, evt_data,
        input  evt_ready, voice_gate, voice_note, voice_data,
        input  voice_trig, steal, drop
    );

    modport slave (
        input  evt_valid, evt_on, evt_note, evt_data,
        output evt_ready, voice_gate, voice_note, voice_data,
        output voice_trig, steal, drop
    );

endinterface
`default_nettype wire

// File: rtl/onehot_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_prio_enc
//  Description : Lowest-set-bit priority encoder with one-hot output and an
//                "any bit set" flag.
//  Revision    : 1.0  initial release
// ============================================================================
module onehot_prio_enc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic             any_o
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot_o = vec_i & (~vec_i + WIDTH'(1));
    assign any_o    = |vec_i;

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : voice_allocator
//  Description : Assigns note-on/note-off events to voice slots. Three-cycle
//                IDLE -> MATCH -> APPLY sequence per event; holds per-voice
//                gate/note/data registers and pulses trig/steal/drop.
//                Build option VOICE_ALLOC_STEAL_EN: when defined, a note-on
//                with every voice gated steals the round-robin voice; when
//                undefined it is dropped and steal is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module voice_allocator
    import synth_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    voice_allocator_if.slave bus
);

    alloc_state_t      state_q,  state_d;
    note_evt_t         evt_q,    evt_d;
    alloc_action_t     action_q, action_d;
    voice_onehot_t     target_q, target_d;
    voice_onehot_t     gate_q,   gate_d;
    logic [NOTE_W-1:0] note_q [NUM_VOICES];
    logic [NOTE_W-1:0] note_d [NUM_VOICES];
    logic [DW-1:0]     data_q [NUM_VOICES];
    logic [DW-1:0]     data_d [NUM_VOICES];
    voice_onehot_t     trig_q,   trig_d;
    logic              drop_q,   drop_d;
`ifdef VOICE_ALLOC_STEAL_EN
    logic              steal_q,  steal_d;
    logic [PTR_W-1:0]  steal_ptr_q, steal_ptr_d;
`endif

    voice_onehot_t     match_vec;
    voice_onehot_t     free_vec;
    voice_onehot_t     match_oh;
    voice_onehot_t     free_oh;
    logic              match_any;
    logic              free_any;

    // Voices currently holding the captured note (at most one by construction).
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            match_vec[i] = gate_q[i] && (note_q[i] == evt_q.note);
        end
    end

    assign free_vec = ~gate_q;

    onehot_prio_enc #(.WIDTH(NUM_VOICES)) u_match_enc (
        .vec_i    (match_vec),
        .onehot_o (match_oh),
        .any_o    (match_any)
    );

    onehot_prio_enc #(.WIDTH(NUM_VOICES)) u_free_enc (
        .vec_i    (free_vec),
        .onehot_o (free_oh),
        .any_o    (free_any)
    );

    // Next-state: capture in IDLE, decide in MATCH, write voice regs in APPLY.
    always_comb begin
        state_d  = state_q;
        evt_d    = evt_q;
        action_d = action_q;
        target_d = target_q;
        gate_d   = gate_q;
        note_d   = note_q;
        data_d   = data_q;
        trig_d   = '0;
        drop_d   = 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
        steal_d     = 1'b0;
        steal_ptr_d = steal_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.evt_valid) begin
                    evt_d.on   = bus.evt_on;
                    evt_d.note = bus.evt_note;
                    evt_d.data = bus.evt_data;
                    state_d    = MATCH;
                end
            end
            MATCH: begin
                if (evt_q.on) begin
                    if (match_any) begin
                        action_d = RETRIG;
                        target_d = match_oh;
                    end else if (free_any) begin
                        action_d = ALLOC;
                        target_d = free_oh;
                    end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                        action_d = STEAL;
                        target_d = voice_onehot_t'(1) << steal_ptr_q;
`else
                        action_d = DROP;
                        target_d = '0;
`endif
                    end
                end else if (match_any) begin
                    action_d = RELEASE;
                    target_d = match_oh;
                end else begin
                    action_d = DROP;
                    target_d = '0;
                end
                state_d = APPLY;
            end
            APPLY: begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (target_q[i]) begin
                        if (action_q == ALLOC)   gate_d[i] = 1'b1;
                        if (action_q == RELEASE) gate_d[i] = 1'b0;
                        if (action_q inside {ALLOC, STEAL})
                            note_d[i] = evt_q.note;
                        if (action_q inside {RETRIG, ALLOC, STEAL})
                            data_d[i] = evt_q.data;
                    end
                end
                if (action_q inside {RETRIG, ALLOC, STEAL}) trig_d = target_q;
                if (action_q == DROP) drop_d = 1'b1;
`ifdef VOICE_ALLOC_STEAL_EN
                if (action_q == STEAL) begin
                    steal_d     = 1'b1;
                    steal_ptr_d = (steal_ptr_q == PTR_W'(NUM_VOICES - 1)) ?
                                  '0 : steal_ptr_q + 1'b1;
                end
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, event and voice registers; reset discards any in-flight event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            evt_q    <= '0;
            action_q <= DROP;
            target_q <= '0;
            gate_q   <= '0;
            note_q   <= '{default: '0};
            data_q   <= '{default: '0};
            trig_q   <= '0;
            drop_q   <= 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
            steal_q     <= 1'b0;
            steal_ptr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            evt_q    <= evt_d;
            action_q <= action_d;
            target_q <= target_d;
            gate_q   <= gate_d;
            note_q   <= note_d;
            data_q   <= data_d;
            trig_q   <= trig_d;
            drop_q   <= drop_d;
`ifdef VOICE_ALLOC_STEAL_EN
            steal_q     <= steal_d;
            steal_ptr_q <= steal_ptr_d;
`endif
        end
    end

    assign bus.evt_ready  = (state_q == IDLE);
    assign bus.voice_gate = gate_q;
    assign bus.voice_note = note_q;
    assign bus.voice_data = data_q;
    assign bus.voice_trig = trig_q;
    assign bus.drop       = drop_q;
`ifdef VOICE_ALLOC_STEAL_EN
    assign bus.steal      = steal_q;
`else
    assign bus.steal      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Write-side counterpart of the voice-select mux. Takes a serial stream of note-on/note-off events and assigns each one to one of NUM_VOICES voice slots.
- Holds per-voice note/data/gate registers. These are the arrays the output mux later reads.
- Emits a one-hot trigger per assignment.
- Sits between the MIDI/key decoder and the oscillator/envelope bank.

Parameters:
- NUM_VOICES, 8, number of voice slots; one-hot width.
- DW, 16, width of per-voice data word (phase increment).
- NOTE_W, 7, width of note number.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- evt_valid  in  1  event present.
- evt_ready  out  1  block can accept an event.
- evt_on  in  1  1 = note-on, 0 = note-off.
- evt_note  in  NOTE_W  note number.
- evt_data  in  DW  phase increment for note-on; ignored for note-off.
- voice_gate  out  NUM_VOICES  per-voice gate (key held).
- voice_note  out  NOTE_W x NUM_VOICES  unpacked array, note held by each voice.
- voice_data  out  DW x NUM_VOICES  unpacked array, data word per voice.
- voice_trig  out  NUM_VOICES  one-cycle one-hot pulse on note-on assignment.
- steal  out  1  one-cycle pulse when an assignment overwrote a gated voice.
- drop  out  1  one-cycle pulse when an event was discarded.

Behaviour:
- Reset:
  - voice_gate = 0, voice_note = 0, voice_data = 0.
  - voice_trig = 0, steal = 0, drop = 0.
  - steal_ptr = 0; state = IDLE.
  - Any in-flight event is discarded. Reset mid-operation is handled the same way: no partial write occurs.
- FSM states: IDLE, MATCH, APPLY.
- IDLE:
  - evt_ready = 1.
  - On evt_valid & evt_ready, capture evt_on/evt_note/evt_data into the event register and go to MATCH.
- MATCH:
  - evt_ready = 0.
  - Compute match_vec[i] = voice_gate[i] & (voice_note[i] == captured note).
  - Compute free_vec = ~voice_gate.
  - Register the target one-hot and the action (retrigger, allocate, steal, release, drop). Go to APPLY.
- APPLY:
  - evt_ready = 0.
  - Perform the action on the clock edge, pulse outputs for exactly the following cycle, then return to IDLE.
- Timing:
  - Accept at edge N → voice registers and pulses visible after edge N+2.
  - Throughput is one event per 3 cycles.
  - evt_valid held while busy is stalled, not lost.
- Note-on priority:
  - (1) match_vec != 0: retrigger the matching voice. Write data, trig. No duplicate notes ever exist.
  - (2) else free_vec != 0: allocate the lowest-index free voice. Set gate, write note and data, trig.
  - (3) else all voices gated: steal voice steal_ptr. Write note, data and trig; assert steal. steal_ptr increments modulo NUM_VOICES (wraps 7→0).
  - steal_ptr changes only on a steal.
- Note-off:
  - match_vec != 0: clear gate of the matching voice. voice_note and voice_data are retained for the release phase. No trig.
  - match_vec == 0: drop pulse, no state change.
- Invariants:
  - voice_trig is zero or exactly one-hot.
  - steal and drop are never both high.
  - At most one voice is written per event.

Optional Feature:
- Macro: VOICE_ALLOC_STEAL_EN.
- Defined: note-on with all voices gated steals as above; steal port is live.
- Undefined: that note-on is discarded (drop pulse, no register change). steal is tied to 0 and steal_ptr is not implemented.

Decomposition:
- Package synth_pkg holds:
  - constants NUM_VOICES, DW, NOTE_W;
  - typedef voice_onehot_t (logic [NUM_VOICES-1:0]);
  - enum alloc_state_t {IDLE, MATCH, APPLY};
  - enum alloc_action_t {RETRIG, ALLOC, STEAL, RELEASE, DROP};
  - struct note_evt_t {on, note, data}.
- One sub-module: onehot_prio_enc. Input is a vector; output is the one-hot of the lowest set bit plus an any flag. Used for both match_vec and free_vec.

Test Plan:
- Reset, then note-on note 60 data 0x1234 → after 3 cycles: voice_gate = 0x01, voice_note[0] = 60, voice_data[0] = 0x1234, voice_trig = 0x01 for 1 cycle.
- Note-on 60, 62, 64, then note-off 62, then note-on 67 → gate 0x07 → 0x05 → 0x07. Note 67 lands in voice 1; voice_data[1] is the new value.
- Note-on 60 twice with data 0x1000 then 0x2000 → only voice 0 gated; voice_data[0] = 0x2000; trig 0x01 twice; no steal.
- Nine distinct note-ons (STEAL_EN defined) → ninth: steal = 1, voice_trig = 0x01, steal_ptr = 1. A tenth note-on steals voice 1 (trig 0x02).
- Same nine note-ons (STEAL_EN undefined) → ninth: drop = 1, no trig, registers unchanged. Separately, note-off 99 with no match → drop = 1, gate unchanged.
- evt_valid held continuously with 4 events, reset asserted in the MATCH cycle of event 2 → all outputs zero next cycle, evt_ready = 1. Event 2 is never applied.
